// File: rtl/clamp_stream.sv
// Streaming saturating clamp: runtime bounds, signed/unsigned compare,
// 2-stage valid/ready pipeline with backpressure and saturation statistics.
module clamp_stream #(
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       CNT_W  = 16,
  parameter logic [DATA_W-1:0] LO_RST = '0,
  parameter logic [DATA_W-1:0] HI_RST = {1'b0, {(DATA_W-1){1'b1}}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [DATA_W-1:0] cfg_lo,
  input  logic [DATA_W-1:0] cfg_hi,
  input  logic              cfg_signed,
  input  logic              stat_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic [CNT_W-1:0]  lo_hits,
  output logic [CNT_W-1:0]  hi_hits,
  output logic              sat_sticky,
  output logic              cfg_err
);

  // Active bounds and compare mode
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;
  logic              signed_q;

  // Stage 1: sample, compare flags and the bound it would saturate to
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] s1_bnd;
  logic              s1_lo;
  logic              s1_hi;

  // Stage 2 side info: which bound the presented sample was clamped to
  logic              s2_lo;
  logic              s2_hi;

  logic              adv1;
  logic              adv2;
  logic              fire;
  logic              lt_lo_c;
  logic              gt_hi_c;
  logic              cfg_err_nxt_c;

  // a < b under the selected compare mode
  function automatic logic less_than(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic              sgn);
    if (sgn) begin
      less_than = $signed(a) < $signed(b);
    end else begin
      less_than = a < b;
    end
  endfunction

  // Handshake: a stage advances when its successor is empty or draining
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign fire     = out_valid && out_ready;

  // Compare flags; inconsistent bounds force every sample to the lower bound
  always_comb begin
    lt_lo_c       = cfg_err || less_than(in_data, lo_q, signed_q);
    gt_hi_c       = !lt_lo_c && less_than(hi_q, in_data, signed_q);
    cfg_err_nxt_c = less_than(cfg_hi, cfg_lo, cfg_signed);
  end

  // Bound/mode registers; cfg_err tracks the bounds it describes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_q     <= LO_RST;
      hi_q     <= HI_RST;
      signed_q <= 1'b0;
      cfg_err  <= 1'b0;
    end else if (cfg_we) begin
      lo_q     <= cfg_lo;
      hi_q     <= cfg_hi;
      signed_q <= cfg_signed;
      cfg_err  <= cfg_err_nxt_c;
    end
  end

  // Stage 1: capture accepted sample with flags computed against current bounds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_bnd   <= '0;
      s1_lo    <= 1'b0;
      s1_hi    <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_bnd  <= lt_lo_c ? lo_q : hi_q;
        s1_lo   <= lt_lo_c;
        s1_hi   <= gt_hi_c;
      end
    end
  end

  // Stage 2: select clamped result; held while downstream stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      s2_lo     <= 1'b0;
      s2_hi     <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= (s1_lo || s1_hi) ? s1_bnd : s1_data;
        out_sat  <= s1_lo || s1_hi;
        s2_lo    <= s1_lo;
        s2_hi    <= s1_hi;
      end
    end
  end

  // Saturation statistics on output handshake; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_hits    <= '0;
      hi_hits    <= '0;
      sat_sticky <= 1'b0;
    end else if (stat_clr) begin
      lo_hits    <= '0;
      hi_hits    <= '0;
      sat_sticky <= 1'b0;
    end else if (fire) begin
      if (s2_lo && (lo_hits != {CNT_W{1'b1}})) begin
        lo_hits <= lo_hits + CNT_W'(1);
      end
      if (s2_hi && (hi_hits != {CNT_W{1'b1}})) begin
        hi_hits <= hi_hits + CNT_W'(1);
      end
      if (out_sat) begin
        sat_sticky <= 1'b1;
      end
    end
  end

endmodule
